// File: rtl/switch_event_arbiter_pkg.sv
// Shared definitions for the switch event arbiter.
// Contents:
//   EV_RELEASE / EV_PRESS : encoding of an event direction (falling / rising edge)
//   ST_IDLE / ST_PRESENT  : arbiter FSM state encoding
package switch_event_arbiter_pkg;

    localparam logic EV_RELEASE = 1'b0;
    localparam logic EV_PRESS   = 1'b1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

endpackage

// File: rtl/switch_debounce_channel.sv
// One debounced switch channel: two-flop synchronizer, stable-tick counter,
// committed state and a one-deep pending-event slot.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_switch         : raw asynchronous switch level
//   i_tick           : shared sample tick, one cycle wide
//   i_clear          : arbiter has taken this channel's pending event
//   o_state          : debounced level (registered)
//   o_pending        : an event is waiting for the arbiter
//   o_pdir           : direction of the pending event (EV_PRESS / EV_RELEASE)
//   o_overflow_hit   : a commit is overwriting a pending event this cycle
module switch_debounce_channel
    import switch_event_arbiter_pkg::*;
#(
    parameter int STABLE_TICKS = 1000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_switch,
    input  logic i_tick,
    input  logic i_clear,
    output logic o_state,
    output logic o_pending,
    output logic o_pdir,
    output logic o_overflow_hit
);

    localparam int CNT_W = $clog2(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             state_q;
    logic             state_d;
    logic             pending_q;
    logic             pending_d;
    logic             pdir_q;
    logic             pdir_d;
    logic             commit_s;

    // Stable counter and state: only advance on a sample tick.
    always_comb begin
        commit_s = 1'b0;
        count_d  = count_q;
        state_d  = state_q;
        if (i_tick) begin
            if (sync2_q == state_q) begin
                count_d = '0;
            end else if (count_q == CNT_LAST) begin
                commit_s = 1'b1;
                state_d  = sync2_q;
                count_d  = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Pending slot: a new commit beats a same-cycle clear from the arbiter.
    always_comb begin
        pending_d = pending_q;
        pdir_d    = pdir_q;
        if (commit_s) begin
            pending_d = 1'b1;
            pdir_d    = sync2_q ? EV_PRESS : EV_RELEASE;
        end else if (i_clear) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Synchronizer, counter, state and pending registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            count_q   <= '0;
            state_q   <= 1'b0;
            pending_q <= 1'b0;
            pdir_q    <= 1'b0;
        end else begin
            sync1_q   <= i_switch;
            sync2_q   <= sync1_q;
            count_q   <= count_d;
            state_q   <= state_d;
            pending_q <= pending_d;
            pdir_q    <= pdir_d;
        end
    end

    // An overwrite only counts when the old event was not being taken this cycle.
    assign o_overflow_hit = commit_s & pending_q & ~i_clear;
    assign o_state        = state_q;
    assign o_pending      = pending_q;
    assign o_pdir         = pdir_q;

endmodule

// File: rtl/switch_event_arbiter.sv
// Debounces NUM_SWITCHES switches and arbitrates their press/release events
// round-robin onto a single valid/ready event port.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_switches     : raw asynchronous switch levels
//   o_debounced    : debounced levels
//   o_event_valid  : an event is presented
//   i_event_ready  : consumer accepts the presented event
//   o_event_id     : channel of the presented event
//   o_event_press  : 1 = press (rising), 0 = release (falling)
//   o_overflow     : one-cycle pulse when a pending event was overwritten
module switch_event_arbiter
    import switch_event_arbiter_pkg::*;
#(
    parameter int NUM_SWITCHES = 4,
    parameter int TICK_DIVIDE  = 250,
    parameter int STABLE_TICKS = 1000
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [NUM_SWITCHES-1:0]         i_switches,
    output logic [NUM_SWITCHES-1:0]         o_debounced,
    output logic                            o_event_valid,
    input  logic                            i_event_ready,
    output logic [$clog2(NUM_SWITCHES)-1:0] o_event_id,
    output logic                            o_event_press,
    output logic                            o_overflow
);

    localparam int ID_W  = $clog2(NUM_SWITCHES);
    localparam int PRE_W = $clog2(TICK_DIVIDE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIVIDE - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_SWITCHES - 1);

    logic [PRE_W-1:0]        presc_q;
    logic                    tick_s;
    logic [NUM_SWITCHES-1:0] state_vec_s;
    logic [NUM_SWITCHES-1:0] pending_s;
    logic [NUM_SWITCHES-1:0] pdir_s;
    logic [NUM_SWITCHES-1:0] ovf_hit_s;
    logic [NUM_SWITCHES-1:0] clear_s;
    logic                    hi_found_s;
    logic                    lo_found_s;
    logic [ID_W-1:0]         hi_id_s;
    logic [ID_W-1:0]         lo_id_s;
    logic                    hi_dir_s;
    logic                    lo_dir_s;
    logic                    grant_found_s;
    logic [ID_W-1:0]         grant_id_s;
    logic                    grant_dir_s;
    logic [0:0]              fsm_q;
    logic [0:0]              fsm_d;
    logic                    valid_q;
    logic                    valid_d;
    logic [ID_W-1:0]         id_q;
    logic [ID_W-1:0]         id_d;
    logic                    press_q;
    logic                    press_d;
    logic [ID_W-1:0]         ptr_q;
    logic [ID_W-1:0]         ptr_d;
    logic                    overflow_q;

    assign tick_s = (presc_q == PRE_LAST);

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_ch
        switch_debounce_channel #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_switch       (i_switches[g]),
            .i_tick         (tick_s),
            .i_clear        (clear_s[g]),
            .o_state        (state_vec_s[g]),
            .o_pending      (pending_s[g]),
            .o_pdir         (pdir_s[g]),
            .o_overflow_hit (ovf_hit_s[g])
        );
    end

    // Round-robin pick: lowest pending index >= ptr, else lowest pending index
    // below ptr. Scanning downwards lets the last hit be the lowest index.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_id_s    = '0;
        lo_id_s    = '0;
        hi_dir_s   = 1'b0;
        lo_dir_s   = 1'b0;
        for (int j = NUM_SWITCHES - 1; j >= 0; j--) begin
            if (pending_s[j] && (ID_W'(j) >= ptr_q)) begin
                hi_found_s = 1'b1;
                hi_id_s    = ID_W'(j);
                hi_dir_s   = pdir_s[j];
            end else if (pending_s[j]) begin
                lo_found_s = 1'b1;
                lo_id_s    = ID_W'(j);
                lo_dir_s   = pdir_s[j];
            end else begin
                hi_found_s = hi_found_s;
            end
        end
        grant_found_s = hi_found_s | lo_found_s;
        grant_id_s    = hi_found_s ? hi_id_s  : lo_id_s;
        grant_dir_s   = hi_found_s ? hi_dir_s : lo_dir_s;
    end

    // Clear the granted channel's pending flag in the cycle the grant is latched.
    always_comb begin
        clear_s = '0;
        for (int j = 0; j < NUM_SWITCHES; j++) begin
            if ((fsm_q == ST_IDLE) && grant_found_s && (grant_id_s == ID_W'(j))) begin
                clear_s[j] = 1'b1;
            end else begin
                clear_s[j] = 1'b0;
            end
        end
    end

    // Arbiter FSM: IDLE latches a grant, PRESENT holds it until accepted.
    always_comb begin
        fsm_d   = fsm_q;
        valid_d = valid_q;
        id_d    = id_q;
        press_d = press_q;
        ptr_d   = ptr_q;
        case (fsm_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    id_d    = grant_id_s;
                    press_d = grant_dir_s;
                    valid_d = 1'b1;
                    fsm_d   = ST_PRESENT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            ST_PRESENT: begin
                if (i_event_ready) begin
                    valid_d = 1'b0;
                    fsm_d   = ST_IDLE;
                    ptr_d   = (id_q == ID_LAST) ? '0 : id_q + ID_W'(1);
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                fsm_d   = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Prescaler, FSM, output and overflow registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q    <= '0;
            fsm_q      <= ST_IDLE;
            valid_q    <= 1'b0;
            id_q       <= '0;
            press_q    <= 1'b0;
            ptr_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            presc_q    <= tick_s ? '0 : presc_q + PRE_W'(1);
            fsm_q      <= fsm_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            press_q    <= press_d;
            ptr_q      <= ptr_d;
            overflow_q <= |ovf_hit_s;
        end
    end

    assign o_debounced   = state_vec_s;
    assign o_event_valid = valid_q;
    assign o_event_id    = id_q;
    assign o_event_press = press_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_switch_event_arbiter.sv
// Directed testbench for switch_event_arbiter with NUM_SWITCHES=4,
// TICK_DIVIDE=4, STABLE_TICKS=3. Expected values are hand-derived.
module tb_switch_event_arbiter;

    localparam int BOUND = 18;  // 2 sync + 3 ticks * 4 + 4 tick phase

    typedef struct {
        int id;
        int press;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw;
    logic [3:0] deb;
    logic       valid;
    logic       ready;
    logic [1:0] id;
    logic       press;
    logic       ovf;

    int  tests_run    = 0;
    int  tests_failed = 0;
    int  cyc          = 0;
    int  ovf_cnt      = 0;
    int  valid_cnt    = 0;
    ev_t evq[$];

    always #5 clk = ~clk;

    switch_event_arbiter #(
        .NUM_SWITCHES(4),
        .TICK_DIVIDE (4),
        .STABLE_TICKS(3)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_switches    (sw),
        .o_debounced   (deb),
        .o_event_valid (valid),
        .i_event_ready (ready),
        .o_event_id    (id),
        .o_event_press (press),
        .o_overflow    (ovf)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Event log: an event is accepted at the edge following valid & ready.
    always @(negedge clk) begin
        if (valid && ready) evq.push_back('{int'(id), int'(press), cyc});
        if (ovf) ovf_cnt++;
        if (valid) valid_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        evq.delete();
        ovf_cnt   = 0;
        valid_cnt = 0;
    endtask

    function automatic ev_t ev_at(input int k);
        ev_t e;
        if (k < evq.size()) e = evq[k];
        else e = '{-1, -1, -1};
        return e;
    endfunction

    task automatic wait_deb(input int b, input logic lvl, input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (deb[b] !== lvl && waited < limit);
    endtask

    task automatic wait_events(input int n, input int limit);
        int waited;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (evq.size() < n && waited < limit);
    endtask

    // Called at posedge+1: one clock edge with rst high.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  w;
        int  glitch;
        ev_t e0, e1, e2;

        rst = 1'b1;
        sw = 4'b0000;
        ready = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_deb", deb, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_id", id, 0);
        check_eq("rst_press", press, 0);

        // Quiet inputs: nothing happens.
        clear_log();
        repeat (200) @(posedge clk);
        #1;
        check_eq("idle_deb", deb, 0);
        check_eq("idle_valid_cnt", valid_cnt, 0);
        check_eq("idle_ovf_cnt", ovf_cnt, 0);

        // Single clean press on ch1.
        ready = 1'b1;
        clear_log();
        sw = 4'b0010;
        wait_deb(1, 1'b1, BOUND, w);
        check_eq("t2_deb_rise", deb, 4'b0010);
        @(negedge clk);
        check_eq("t2_valid", valid, 1);
        check_eq("t2_id", id, 1);
        check_eq("t2_press", press, 1);
        repeat (20) @(negedge clk);
        check_eq("t2_nevents", evq.size(), 1);

        // Bouncing ch0 never reaches 3 clean ticks, then settles high.
        @(posedge clk);
        #1;
        clear_log();
        glitch = 0;
        for (int i = 0; i < 40; i++) begin
            sw[0] = (((i / 5) % 2) == 0);
            @(posedge clk);
            #1;
            if (deb[0] !== 1'b0) glitch++;
        end
        sw[0] = 1'b1;
        wait_deb(0, 1'b1, BOUND, w);
        check_eq("t3_glitch", glitch, 0);
        check_eq("t3_deb", deb, 4'b0011);
        check_eq("t3_not_early", (w >= 10), 1);
        repeat (20) @(negedge clk);
        e0 = ev_at(0);
        check_eq("t3_nevents", evq.size(), 1);
        check_eq("t3_id", e0.id, 0);
        check_eq("t3_press", e0.press, 1);

        // ch0, ch2, ch3 commit together with ptr=0.
        @(posedge clk);
        #1;
        sw = 4'b0000;
        do_reset();
        clear_log();
        sw = 4'b1101;
        wait_events(3, 40);
        e0 = ev_at(0);
        e1 = ev_at(1);
        e2 = ev_at(2);
        check_eq("t4a_n", evq.size(), 3);
        check_eq("t4a_id0", e0.id, 0);
        check_eq("t4a_id1", e1.id, 2);
        check_eq("t4a_id2", e2.id, 3);
        check_eq("t4a_gap1", e1.cyc - e0.cyc, 2);
        check_eq("t4a_gap2", e2.cyc - e1.cyc, 2);
        check_eq("t4a_press", e0.press + e1.press + e2.press, 3);

        // ptr back at 0: ch0 and ch3 release together.
        @(posedge clk);
        #1;
        clear_log();
        sw = 4'b0100;
        wait_events(2, 40);
        e0 = ev_at(0);
        e1 = ev_at(1);
        check_eq("t4b_n", evq.size(), 2);
        check_eq("t4b_id0", e0.id, 0);
        check_eq("t4b_id1", e1.id, 3);
        check_eq("t4b_press", e0.press + e1.press, 0);

        // ch0 press alone moves ptr to 1.
        @(posedge clk);
        #1;
        clear_log();
        sw = 4'b0101;
        wait_events(1, 40);
        e0 = ev_at(0);
        check_eq("t4c_id", e0.id, 0);
        check_eq("t4c_press", e0.press, 1);

        // ptr=1: ch0 and ch2 release together -> 2 then 0.
        @(posedge clk);
        #1;
        clear_log();
        sw = 4'b0000;
        wait_events(2, 40);
        e0 = ev_at(0);
        e1 = ev_at(1);
        check_eq("t4d_n", evq.size(), 2);
        check_eq("t4d_id0", e0.id, 2);
        check_eq("t4d_id1", e1.id, 0);
        check_eq("t4d_press", e0.press + e1.press, 0);

        // Back-pressure and overwrite on ch2.
        @(posedge clk);
        #1;
        clear_log();
        ready = 1'b0;
        sw = 4'b0100;
        wait_deb(2, 1'b1, BOUND, w);
        check_eq("t5_deb_p1", deb, 4'b0100);
        @(negedge clk);
        check_eq("t5_valid", valid, 1);
        check_eq("t5_id", id, 2);
        check_eq("t5_press", press, 1);
        @(posedge clk);
        #1;
        sw = 4'b0000;
        wait_deb(2, 1'b0, BOUND, w);
        check_eq("t5_deb_rel", deb, 4'b0000);
        check_eq("t5_hold_valid", valid, 1);
        check_eq("t5_hold_press", press, 1);
        check_eq("t5_no_ovf_yet", ovf_cnt, 0);
        @(posedge clk);
        #1;
        sw = 4'b0100;
        wait_deb(2, 1'b1, BOUND, w);
        repeat (3) @(negedge clk);
        check_eq("t5_ovf_cnt", ovf_cnt, 1);
        check_eq("t5_hold_id", id, 2);
        @(posedge clk);
        #1;
        ready = 1'b1;
        wait_events(2, 20);
        e0 = ev_at(0);
        e1 = ev_at(1);
        check_eq("t5_n", evq.size(), 2);
        check_eq("t5_ev0", e0.id * 2 + e0.press, 5);
        check_eq("t5_ev1", e1.id * 2 + e1.press, 5);

        // Reset while presenting ch3 with ch1 still pending.
        @(posedge clk);
        #1;
        clear_log();
        ready = 1'b0;
        sw = 4'b1110;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (valid !== 1'b1 && w < 40);
        check_eq("t6_valid", valid, 1);
        check_eq("t6_id", id, 3);
        @(posedge clk);
        #1;
        sw = 4'b0000;
        do_reset();
        check_eq("t6_rst_valid", valid, 0);
        check_eq("t6_rst_deb", deb, 0);
        clear_log();
        ready = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("t6_no_valid", valid_cnt, 0);
        check_eq("t6_no_events", evq.size(), 0);
        check_eq("t6_deb", deb, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/switch_event_arbiter.md
Name: switch_event_arbiter

Overview:
- Debounces NUM_SWITCHES bouncy switch inputs and arbitrates their press/release events onto one valid/ready event port.
- One shared prescaler produces a sample tick for all channels. Each channel has its own stable-tick counter.
- Committed edges are queued one-deep per channel and granted round-robin.
- Sits between board switches and the consumers of switch events, such as LED/mode control.

Parameters:
- NUM_SWITCHES, 4: number of switch channels; must be at least 2.
- TICK_DIVIDE, 250: clocks per sample tick; must be at least 2.
- STABLE_TICKS, 1000: consecutive differing ticks needed to commit a change; must be at least 2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_switches  in  NUM_SWITCHES  raw asynchronous switch levels
- o_debounced  out  NUM_SWITCHES  debounced levels
- o_event_valid  out  1  event presented
- i_event_ready  in  1  consumer accepts event
- o_event_id  out  $clog2(NUM_SWITCHES)  channel of the presented event
- o_event_press  out  1  1 = rising (press), 0 = falling (release)
- o_overflow  out  1  one-cycle pulse when an unconsumed pending event is overwritten

Behaviour:
- Reset (one clock edge with i_rst=1): all outputs 0; synchronizers, states, counters, pending flags, prescaler and RR pointer all 0; FSM to IDLE. Reset mid-operation drops o_event_valid on the next edge and discards every pending event.
- Synchronizer: two flops per channel; the second flop is the sample s[i].
- Prescaler: counts 0..TICK_DIVIDE-1 and wraps. tick=1 in the cycle the count equals TICK_DIVIDE-1.
- Per channel, evaluated on tick only:
  - s==state: count<=0.
  - s!=state and count<STABLE_TICKS-1: count<=count+1.
  - s!=state and count==STABLE_TICKS-1: commit. state<=s, count<=0, pending<=1, pdir<=s.
- Per channel, between ticks: count and state hold.
- o_debounced = state (registered). A level held high through reset therefore yields a press event after the stable window.
- Overflow: a commit while pending=1 overwrites pdir with the newest direction and pulses o_overflow on the following cycle.
- Arbiter FSM:
  - IDLE: if any pending, select the first pending index at or after ptr, searching cyclically. Latch id and pdir into the output registers, clear that channel's pending, go to PRESENT.
  - PRESENT: o_event_valid=1. id and direction are held stable until i_event_ready=1.
  - On valid&ready: ptr<=(id+1) mod NUM_SWITCHES, valid<=0, go to IDLE.
- Throughput and latency:
  - At most one event per 2 cycles, because of the IDLE bubble.
  - o_event_valid rises 1 cycle after o_debounced changes when the FSM is IDLE with nothing else pending.
- Simultaneous events:
  - A commit on the same edge the arbiter clears that channel's pending: the set wins, the new event stays pending and no overflow is raised.
  - Multiple channels committing on one tick: all become pending and are granted in RR order.
- Holding i_event_ready high while IDLE has no effect.

Decomposition:
- Shared package: event-direction constants (EV_RELEASE=0, EV_PRESS=1) and FSM state encoding (ST_IDLE, ST_PRESENT).
- One natural sub-module, switch_debounce_channel: synchronizer, stable counter, state, pending and pdir for one channel. It is instantiated NUM_SWITCHES times with a generate loop and shares the tick.
- The prescaler, the RR selection and the FSM stay in the top.

Test Plan:
All scenarios use NUM_SWITCHES=4, TICK_DIVIDE=4, STABLE_TICKS=3.
- Reset, all inputs low for 200 cycles -> o_debounced=0000, o_event_valid never 1, o_overflow never 1.
- ch1 steps 0->1, ready=1 -> o_debounced[1] rises within 2+3*4+4 cycles. One cycle later valid=1 with id=1, press=1. Exactly one event.
- ch0 toggles every 5 cycles for 40 cycles, then stays at 1 -> o_debounced[0] has no glitch, rising once only after 3 clean ticks. Exactly one press event.
- ch0, ch2 and ch3 commit on the same tick with ptr=0, ready=1 -> events id 0, 2, 3 in order, 2 cycles apart. Then ch0 and ch3 commit together with ptr=0 -> order 0, 3. With ptr=1, ch0 and ch2 commit together -> order 2, 0.
- ready=0: ch2 commits press, release, press -> the first press is held at the output; the second press overwrites the pending release and o_overflow pulses once. After ready=1 -> events (2, press) then (2, press).
- Assert i_rst for one cycle during PRESENT with ch1 pending -> valid=0 next cycle, o_debounced=0, and no further event appears unless the inputs re-commit.
